instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 144 ++++++++++++++
 tb/tb_instr_encoder.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Purpose  : Encodes field bundles into 32-bit instruction words and streams
//            them to instruction memory at consecutive word addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_kind,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);

    localparam logic [ADDR_WIDTH-1:0] C_BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   C_COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [1:0]            C_KIND_R    = 2'd0;
    localparam logic [1:0]            C_KIND_ADDI = 2'd1;
    localparam logic [1:0]            C_KIND_ORI  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_out_valid;
    logic [31:0]             r_out_instr;
    logic [ADDR_WIDTH-1:0]   r_out_addr;
    logic [ADDR_WIDTH:0]     r_count;
    logic                    r_wrap;
    logic [31:0]             w_instr;
    logic                    w_accept;
    logic                    w_write;
    logic                    w_load;

    always_comb begin
        w_instr = '0;
        case (in_kind)
            C_KIND_R:    w_instr = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
            C_KIND_ADDI: w_instr = {6'h08, in_rs, in_rt, in_imm};
            C_KIND_ORI:  w_instr = {6'h0D, in_rs, in_rt, in_imm};
            default:     w_instr = {6'h11, in_rs, 5'b0, in_rd, 11'b0};
        endcase
    end

    assign w_accept = in_valid && in_ready;
    assign w_write  = r_out_valid && out_ready;
    assign w_load   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy     = 1'b1;
                in_ready = !r_out_valid || out_ready;
                if (in_valid && in_ready && in_last) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_write) w_state_next = S_DONE;
            end
            default: begin
                done = 1'b1;
                if (start) w_state_next = S_RUN;
            end
        endcase
    end

    // Loading only happens in IDLE/DONE, where no word is held, so it never
    // coincides with a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= C_BASE;
            r_count     <= '0;
            r_wrap      <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_addr <= C_BASE;
                r_count    <= '0;
                r_wrap     <= 1'b0;
            end else if (w_write) begin
                r_out_addr <= r_out_addr + 1'b1;
                if (&r_out_addr) r_wrap <= 1'b1;
                if (r_count != C_COUNT_MAX) r_count <= r_count + 1'b1;
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
            end else if (w_write) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign count     = r_count;
    assign wrap      = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Scoreboard bench for instr_encoder (narrow address space so the
//            counter wraps and the word count saturates often).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int BASE  = 0;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] exp;
    } bundle_t;

    typedef struct {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_kind = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]    in_funct = '0;
    logic [15:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic [AW:0]   count;
    logic          busy, done, wrap;

    wr_t     sb[$];
    bundle_t prog[$];
    int      checks = 0;
    int      errors = 0;
    int      n_writes = 0;
    int      model_addr = BASE;

    instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .count(count), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference encoding: opcode and fields placed by their bit weights.
    function automatic logic [31:0] ref_encode(input bundle_t b);
        int unsigned w;
        case (b.kind)
            2'd0:    w = 32'(b.rs) * 2097152 + 32'(b.rt) * 65536 + 32'(b.rd) * 2048
                       + 32'(b.sh) * 64 + 32'(b.fn);
            2'd1:    w = 32'd8  * 67108864 + 32'(b.rs) * 2097152 + 32'(b.rt) * 65536 + 32'(b.imm);
            2'd2:    w = 32'd13 * 67108864 + 32'(b.rs) * 2097152 + 32'(b.rt) * 65536 + 32'(b.imm);
            default: w = 32'd17 * 67108864 + 32'(b.rs) * 2097152 + 32'(b.rd) * 2048;
        endcase
        return w;
    endfunction

    function automatic bundle_t mk(input int kind, input int rs, input int rt, input int rd,
                                   input int sh, input int fn, input int imm, input logic [31:0] exp);
        bundle_t b;
        b.kind = 2'(kind); b.rs = 5'(rs); b.rt = 5'(rt); b.rd = 5'(rd);
        b.sh = 5'(sh); b.fn = 6'(fn); b.imm = 16'(imm); b.exp = exp;
        return b;
    endfunction

    function automatic bundle_t rnd_bundle();
        bundle_t b;
        b = mk($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
               $urandom_range(0, 65535), 32'h0);
        b.exp = ref_encode(b);
        return b;
    endfunction

    task automatic drive(input bundle_t b, input logic last);
        in_kind = b.kind; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd;
        in_shamt = b.sh; in_funct = b.fn; in_imm = b.imm; in_last = last;
    endtask

    task automatic expect_write(input bundle_t b);
        wr_t e;
        e.instr = b.exp;
        e.addr  = AW'(model_addr);
        sb.push_back(e);
        model_addr = (model_addr + 1) % DEPTH;
    endtask

    // All stimulus tasks begin and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_addr = BASE;
    endtask

    task automatic run_prog(input bit do_start, input int rdy_pct, input int vld_pct);
        int      n = prog.size();
        int      sent = 0;
        int      cyc = 0;
        bit      holding = 1'b0;
        bundle_t cur;
        if (do_start) pulse_start();
        while (sent < n && cyc < 3000) begin
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (!holding && ($urandom_range(0, 99) < vld_pct)) begin
                cur = prog.pop_front();
                holding = 1'b1;
                drive(cur, sent == n - 1);
            end
            in_valid = holding;
            @(negedge clk);
            if (holding && in_ready) begin
                expect_write(cur);
                sent++;
                holding = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        while (!done && cyc < 3000) begin
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        chk("prog_done", done, 1'b1);
        chk("prog_busy", busy, 1'b0);
        chk("prog_out_valid", out_valid, 1'b0);
        chk("prog_count", count, (n < DEPTH) ? n : DEPTH);
        chk("prog_wrap", wrap, (BASE + n >= DEPTH) ? 1 : 0);
        chk("prog_addr", out_addr, (BASE + n) % DEPTH);
        chk("prog_sb_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: every write the memory sees must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_writes++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got instr %h addr %0d expected none", out_instr, out_addr);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_instr", out_instr, e.instr);
                chk("wr_addr", 32'(out_addr), 32'(e.addr));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_out_instr", out_instr, 32'h0);
        chk("idle_out_addr", out_addr, BASE);
        chk("idle_count", count, 0);
        chk("idle_wrap", wrap, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;

        // Single ADDI, then R-type followed by MOV.
        prog.push_back(mk(1, 1, 2, 0, 0, 0, 16'h0005, 32'h20220005));
        run_prog(1'b1, 100, 100);
        prog.push_back(mk(0, 3, 4, 5, 0, 6'h20, 0, 32'h00642820));
        prog.push_back(mk(3, 7, 0, 9, 0, 0, 0, 32'h44E04800));
        run_prog(1'b1, 100, 100);

        // Backpressure on a held ORI.
        pulse_start();
        out_ready = 1'b0;
        drive(mk(2, 0, 8, 0, 0, 0, 16'hFFFF, 32'h3408FFFF), 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_accept_ready", in_ready, 1'b1);
        expect_write(mk(2, 0, 8, 0, 0, 0, 16'hFFFF, 32'h3408FFFF));
        @(posedge clk); #1;
        w0 = n_writes;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_instr", out_instr, 32'h3408FFFF);
            chk("bp_addr", out_addr, BASE);
            chk("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_one_write", n_writes - w0, 1);
        chk("bp_done", done, 1'b1);
        chk("bp_count", count, 1);
        @(posedge clk); #1;

        // Streaming five words through a four-word address space.
        pulse_start();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bundle_t b;
            b = rnd_bundle();
            drive(b, k == 4);
            in_valid = 1'b1;
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1'b1);
            if (k > 0) chk("stream_out_valid", out_valid, 1'b1);
            if (k > 0) chk("stream_count", count, k - 1);
            expect_write(b);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_count4", count, 4);
        chk("stream_wrap", wrap, 1'b1);
        chk("stream_addr5", out_addr, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_count_sat", count, 4);
        chk("stream_done", done, 1'b1);
        chk("stream_final_addr", out_addr, 1);
        @(posedge clk); #1;

        // Reset while a word is held under backpressure.
        pulse_start();
        out_ready = 1'b0;
        drive(rnd_bundle(), 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("mr_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mr_held", out_valid, 1'b1);
        #2;
        reset = 1'b1;
        sb.delete();
        model_addr = BASE;
        w0 = n_writes;
        #1;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_done", done, 1'b0);
        chk("mr_in_ready", in_ready, 1'b0);
        chk("mr_count", count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mr_no_write", n_writes - w0, 0);
        chk("mr_idle", busy, 1'b0);
        @(posedge clk); #1;

        // Start ignored in RUN and DRAIN; start in DONE reloads.
        pulse_start();
        out_ready = 1'b1;
        drive(rnd_bundle(), 1'b0);
        prog.push_back(rnd_bundle());
        drive(prog[0], 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        expect_write(prog.pop_front());
        @(posedge clk); #1;
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("ign_busy", busy, 1'b1);
        chk("ign_count", count, 1);
        chk("ign_addr", out_addr, 1);
        @(posedge clk); #1;
        prog.push_back(rnd_bundle());
        out_ready = 1'b0;
        drive(prog[0], 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        expect_write(prog.pop_front());
        @(posedge clk); #1;
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("ign_drain_busy", busy, 1'b1);
        chk("ign_drain_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ign_done", done, 1'b1);
        chk("ign_count2", count, 2);
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("rs_addr", out_addr, BASE);
        chk("rs_count", count, 0);
        chk("rs_wrap", wrap, 1'b0);
        chk("rs_busy", busy, 1'b1);
        @(posedge clk); #1;
        prog.push_back(rnd_bundle());
        run_prog(1'b0, 100, 100);

        // Randomized programs with gaps and backpressure.
        for (int p = 0; p < 10; p++) begin
            int n;
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) prog.push_back(rnd_bundle());
            run_prog(1'b1, $urandom_range(30, 100), $urandom_range(40, 100));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
